// File: rtl/kv_cmp_tree_pipe.sv
// Pipelined N-way key/value tournament: selects the max- or min-key entry among N masked
// lanes, one tree level per stage, with elastic valid/ready flow on both sides.
module kv_cmp_tree_pipe #(
  parameter  int unsigned N     = 8,
  parameter  int unsigned KEY_W = 16,
  parameter  int unsigned VAL_W = 16,
  localparam int unsigned IDX_W = $clog2(N),
  localparam int unsigned L     = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [N-1:0]       in_lmask,
  input  logic [N*KEY_W-1:0] in_keys,
  input  logic [N*VAL_W-1:0] in_vals,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_found,
  output logic [KEY_W-1:0]   out_key,
  output logic [VAL_W-1:0]   out_val,
  output logic [IDX_W-1:0]   out_idx
);

  // Candidates of stages 1..L are stored back to back; stage k starts at base(k).
  localparam int unsigned R = N - 1;

  function automatic int unsigned base(input int unsigned k);
    return N - ((2 * N) >> k);
  endfunction

  logic [L:1]       sv_q, sv_d, mode_q, mode_d;
  logic [L:0]       sv, md;
  logic [L+1:1]     adv;
  logic             c_v_q   [R];
  logic             c_v_d   [R];
  logic [KEY_W-1:0] c_key_q [R];
  logic [KEY_W-1:0] c_key_d [R];
  logic [VAL_W-1:0] c_val_q [R];
  logic [VAL_W-1:0] c_val_d [R];
  logic [IDX_W-1:0] c_idx_q [R];
  logic [IDX_W-1:0] c_idx_d [R];

  assign sv = {sv_q, in_valid};
  assign md = {mode_q, in_mode};

  always_comb begin
    logic             av, bv, take_b;
    logic [KEY_W-1:0] ak, bk;
    logic [VAL_W-1:0] aval, bval;
    logic [IDX_W-1:0] ai, bi;
    int unsigned      p, q;
    av = 1'b0; bv = 1'b0; take_b = 1'b0;
    ak = '0; bk = '0; aval = '0; bval = '0; ai = '0; bi = '0;
    p = 0; q = 0;

    adv[L+1] = out_ready;
    for (int unsigned k = L; k >= 1; k--) begin
      adv[k] = adv[k+1] | ~sv[k];
    end
    in_ready = adv[1];

    sv_d    = sv_q;
    mode_d  = mode_q;
    c_v_d   = c_v_q;
    c_key_d = c_key_q;
    c_val_d = c_val_q;
    c_idx_d = c_idx_q;

    for (int unsigned k = 1; k <= L; k++) begin
      if (adv[k]) begin
        sv_d[k]   = sv[k-1];
        mode_d[k] = md[k-1];
        for (int unsigned j = 0; j < (N >> k); j++) begin
          // Candidate valid is gated by its stage valid so bubbles never report found.
          if (k == 1) begin
            av   = in_lmask[2*j]   & sv[0];
            bv   = in_lmask[2*j+1] & sv[0];
            ak   = in_keys[(2*j)*KEY_W +: KEY_W];
            bk   = in_keys[(2*j+1)*KEY_W +: KEY_W];
            aval = in_vals[(2*j)*VAL_W +: VAL_W];
            bval = in_vals[(2*j+1)*VAL_W +: VAL_W];
            ai   = IDX_W'(2*j);
            bi   = IDX_W'(2*j+1);
          end else begin
            p    = base(k-1) + 2*j;
            av   = c_v_q[p]   & sv[k-1];
            bv   = c_v_q[p+1] & sv[k-1];
            ak   = c_key_q[p];
            bk   = c_key_q[p+1];
            aval = c_val_q[p];
            bval = c_val_q[p+1];
            ai   = c_idx_q[p];
            bi   = c_idx_q[p+1];
          end
          take_b = !av || (bv && (md[k-1] ? (bk < ak) : (bk > ak)));
          q = base(k) + j;
          c_v_d[q]   = av | bv;
          c_key_d[q] = take_b ? bk : ak;
          c_val_d[q] = take_b ? bval : aval;
          c_idx_d[q] = take_b ? bi : ai;
          if (k == L && !(av | bv)) begin
            c_key_d[q] = '0;
            c_val_d[q] = '0;
            c_idx_d[q] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q   <= '0;
      mode_q <= '0;
      for (int unsigned i = 0; i < R; i++) begin
        c_v_q[i]   <= 1'b0;
        c_key_q[i] <= '0;
        c_val_q[i] <= '0;
        c_idx_q[i] <= '0;
      end
    end else begin
      sv_q    <= sv_d;
      mode_q  <= mode_d;
      c_v_q   <= c_v_d;
      c_key_q <= c_key_d;
      c_val_q <= c_val_d;
      c_idx_q <= c_idx_d;
    end
  end

  assign out_valid = sv_q[L];
  assign out_found = c_v_q[R-1];
  assign out_key   = c_key_q[R-1];
  assign out_val   = c_val_q[R-1];
  assign out_idx   = c_idx_q[R-1];

endmodule

// File: tb/tb_kv_cmp_tree_pipe.sv
// Scoreboard bench for kv_cmp_tree_pipe: a linear-scan reference model queues expected
// winners on accept; a negedge monitor pops and compares every delivered result.
module tb_kv_cmp_tree_pipe;

  localparam int unsigned N     = 8;
  localparam int unsigned KEY_W = 16;
  localparam int unsigned VAL_W = 16;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned L     = 3;

  typedef struct packed {
    logic             found;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
    logic [IDX_W-1:0] idx;
  } res_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               in_mode;
  logic [N-1:0]       in_lmask;
  logic [N*KEY_W-1:0] in_keys;
  logic [N*VAL_W-1:0] in_vals;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_found;
  logic [KEY_W-1:0]   out_key;
  logic [VAL_W-1:0]   out_val;
  logic [IDX_W-1:0]   out_idx;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;

  always #5 clk = ~clk;

  kv_cmp_tree_pipe #(.N(N), .KEY_W(KEY_W), .VAL_W(VAL_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_lmask(in_lmask), .in_keys(in_keys), .in_vals(in_vals),
    .out_valid(out_valid), .out_ready(out_ready), .out_found(out_found),
    .out_key(out_key), .out_val(out_val), .out_idx(out_idx)
  );

  // Winner is the first lane, in index order, holding the extreme key.
  function automatic res_t model(input logic mode, input logic [N-1:0] mask,
                                 input logic [N*KEY_W-1:0] keys,
                                 input logic [N*VAL_W-1:0] vals);
    res_t r;
    logic [KEY_W-1:0] k;
    r = '0;
    for (int i = 0; i < int'(N); i++) begin
      k = keys[i*KEY_W +: KEY_W];
      if (mask[i] && (!r.found || (mode ? (k < r.key) : (k > r.key)))) begin
        r.found = 1'b1;
        r.key   = k;
        r.val   = vals[i*VAL_W +: VAL_W];
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  res_t got, held, exp_r;
  logic stalled = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      got = {out_found, out_key, out_val, out_idx};
      if (stalled) check("stall_hold", 64'({out_valid, got}), 64'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected none", got);
        end else begin
          exp_r = sb.pop_front();
          check("result", 64'(got), 64'(exp_r));
        end
      end
      stalled = out_valid && !out_ready;
      held    = got;
    end
  end

  // Offers one beat; returns at posedge+1 after the accepting edge with in_valid still high.
  task automatic send(input logic mode, input logic [N-1:0] mask,
                      input logic [N*KEY_W-1:0] keys, input logic [N*VAL_W-1:0] vals,
                      output int waits);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_lmask = mask;
    in_keys  = keys;
    in_vals  = vals;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      sb.push_back(model(mode, mask, keys, vals));
    end
    waits = n;
    @(posedge clk);
    #1;
  endtask

  task automatic send_random(output int waits);
    logic               m;
    logic [N-1:0]       mk;
    logic [N*KEY_W-1:0] ks;
    logic [N*VAL_W-1:0] vs;
    m = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       mk = '0;
      1:       mk = '1;
      default: mk = N'($urandom);
    endcase
    for (int i = 0; i < int'(N); i++) begin
      ks[i*KEY_W +: KEY_W] = $urandom_range(0, 1) ? KEY_W'($urandom_range(0, 3)) : KEY_W'($urandom);
      vs[i*VAL_W +: VAL_W] = VAL_W'($urandom);
    end
    send(m, mk, ks, vs, waits);
  endtask

  initial begin
    int                 kv[8] = '{3, 9, 1, 9, 0, 2, 7, 5};
    logic [N*KEY_W-1:0] k1, kf, kz;
    logic [N*VAL_W-1:0] v1;
    int                 w, stalls, lat, n, g;

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_lmask = '0; in_keys = '0; in_vals = '0;
    for (int i = 0; i < int'(N); i++) begin
      k1[i*KEY_W +: KEY_W] = KEY_W'(kv[i]);
      v1[i*VAL_W +: VAL_W] = VAL_W'(i * 16);
      kf[i*KEY_W +: KEY_W] = 16'hFFFF;
      kz[i*KEY_W +: KEY_W] = 16'h0000;
    end
    kz[1*KEY_W +: KEY_W] = 16'hFFFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", 64'({out_valid, out_found, out_key, out_val, out_idx}), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Directed max beat on an empty pipe doubles as the latency measurement.
    send(1'b0, 8'hFF, k1, v1, w);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 64'(lat), 64'(L));
    @(posedge clk);
    #1;

    send(1'b1, 8'hFF, k1, v1, w);
    send(1'b1, 8'hEF, k1, v1, w);
    send(1'b0, 8'h00, k1, v1, w);
    k1[7*KEY_W +: KEY_W] = 16'h1234;
    send(1'b0, 8'h80, k1, v1, w);
    send(1'b0, 8'hFF, kf, v1, w);
    send(1'b1, 8'hFF, kf, v1, w);
    send(1'b0, 8'h03, kz, v1, w);
    send(1'b1, 8'h03, kz, v1, w);

    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      send_random(w);
      stalls += w;
    end
    in_valid = 1'b0;
    check("throughput_stalls", 64'(stalls), 64'(0));

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_random(w);
      g = $urandom_range(0, 2);
      if (g != 0) begin
        in_valid = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));

    // Reset with three beats parked in the stalled pipe.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_random(w);
    in_valid = 1'b0;
    @(negedge clk);
    check("inflight_present", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_midflight", 64'({out_valid, out_found, out_key, out_val, out_idx}), 64'(0));
    sb.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'(1));
    repeat (10) @(negedge clk);
    check("no_stale_beat", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
